// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and divisor clamp helper
package uart_pkg;

    // 200 MHz / (9600 baud * 16 oversample) ~= 1302
    localparam int DIV_DEFAULT_200M = 1302;
    localparam int UART_OVS         = 16;

    // A divisor below 2 cannot produce a separate high and low phase, so it is
    // raised to 2.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < 2) ? 32'd2 : d;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - wrap counter with enable, clear and terminal-count pulse
//
// Ports:
//   clk200 : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   en     : advance the count this cycle
//   clr    : synchronous clear, overrides en
//   last   : terminal value; the count wraps last -> 0
//   cnt    : current count
//   tc     : combinational, high on the edge where the count wraps
module tick_counter #(
    parameter int W = 16
) (
    input  logic         clk200,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // A clear suppresses the wrap so that a restart never emits a tick.
    assign tc = en && !clr && (cnt == last);

    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - baud-rate oversample/bit tick generator with shadowed divisor
//
// Ports:
//   clk200      : 200 MHz system clock
//   rst_n       : asynchronous active-low reset
//   en          : count enable; low freezes counters and clkout
//   restart     : synchronous phase restart, wins over en
//   div_load    : one-cycle strobe capturing div_value into the shadow
//   div_value   : requested divisor N
//   tick_ovs    : one-cycle pulse every N enabled cycles
//   tick_bit    : one-cycle pulse on every OVS-th tick_ovs
//   clkout      : square wave, period N enabled cycles
//   div_active  : divisor currently in use
//   div_pending : shadow holds a divisor not yet applied
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = DIV_DEFAULT_200M,
    parameter int OVS         = UART_OVS,
    parameter int OVS_W       = 4
) (
    input  logic             clk200,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             tick_ovs,
    output logic             tick_bit,
    output logic             clkout,
    output logic [CNT_W-1:0] div_active,
    output logic             div_pending
);

    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(clamp_div(DIV_DEFAULT));
    localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] div_req;
    logic [CNT_W-1:0] per_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             per_tc;
    logic             ovs_tc;
    logic             apply;
    // Only the terminal count of the oversample counter is needed.
    logic [OVS_W-1:0] ovs_cnt_unused;

    assign div_req  = CNT_W'(clamp_div(32'(div_value)));
    assign per_last = div_active - CNT_W'(1);
    assign apply    = restart || per_tc;

    // Count value after this edge; clkout is derived from it so the output
    // is registered yet aligned with the counter.
    assign cnt_next = per_tc ? '0 : cnt + CNT_W'(1);

    tick_counter #(
        .W (CNT_W)
    ) u_period (
        .clk200 (clk200),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (restart),
        .last   (per_last),
        .cnt    (cnt),
        .tc     (per_tc)
    );

    tick_counter #(
        .W (OVS_W)
    ) u_ovs (
        .clk200 (clk200),
        .rst_n  (rst_n),
        .en     (per_tc),
        .clr    (restart),
        .last   (OVS_LAST),
        .cnt    (ovs_cnt_unused),
        .tc     (ovs_tc)
    );

    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            tick_ovs    <= 1'b0;
            tick_bit    <= 1'b0;
            clkout      <= 1'b0;
            div_active  <= DIV_RESET;
            shadow      <= DIV_RESET;
            div_pending <= 1'b0;
        end else begin
            tick_ovs <= per_tc;
            tick_bit <= ovs_tc;

            if (restart) begin
                clkout <= 1'b0;
            end else if (en) begin
                clkout <= (cnt_next >= (div_active >> 1));
            end

            // A load coinciding with an apply edge bypasses the shadow.
            if (apply) begin
                div_active  <= div_load ? div_req : shadow;
                shadow      <= div_load ? div_req : shadow;
                div_pending <= 1'b0;
            end else if (div_load) begin
                shadow      <= div_req;
                div_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - randomized self-checking bench for baud_tick_gen
`timescale 1ns/1ps
module tb_baud_tick_gen;

    localparam int OVS = 16;

    logic        clk200 = 1'b0;
    logic        rst_n;
    logic        en;
    logic        restart;
    logic        div_load;
    logic [15:0] div_value;
    logic        tick_ovs;
    logic        tick_bit;
    logic        clkout;
    logic [15:0] div_active;
    logic        div_pending;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: elapsed enabled cycles in the current period, ticks
    // since the last phase origin, and the divisor bookkeeping.
    int unsigned m_n, m_shadow, m_el, m_ticks;
    bit          m_pend, m_clk, m_tovs, m_tbit;

    int edge_no;
    int first_tovs;
    int first_tbit;

    always #2.5 clk200 = ~clk200;

    baud_tick_gen #(
        .CNT_W       (16),
        .DIV_DEFAULT (1302),
        .OVS         (OVS),
        .OVS_W       (4)
    ) dut (
        .clk200      (clk200),
        .rst_n       (rst_n),
        .en          (en),
        .restart     (restart),
        .div_load    (div_load),
        .div_value   (div_value),
        .tick_ovs    (tick_ovs),
        .tick_bit    (tick_bit),
        .clkout      (clkout),
        .div_active  (div_active),
        .div_pending (div_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
        end
    endtask

    function automatic int unsigned clampv(input int unsigned v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_n = 1302; m_shadow = 1302; m_el = 0; m_ticks = 0;
        m_pend = 0; m_clk = 0; m_tovs = 0; m_tbit = 0;
        edge_no = 0; first_tovs = 0; first_tbit = 0;
    endtask

    task automatic model_edge(input bit e, input bit r, input bit l, input int unsigned v);
        int unsigned req;
        bit          wrapped;
        req = clampv(v);
        m_tovs = 0;
        m_tbit = 0;
        if (r) begin
            m_n = l ? req : m_shadow;
            m_shadow = m_n; m_pend = 0;
            m_el = 0; m_ticks = 0; m_clk = 0;
        end else begin
            wrapped = 0;
            if (e) begin
                m_el++;
                if (m_el == m_n) begin
                    wrapped = 1;
                    m_tovs = 1;
                    m_ticks++;
                    m_tbit = (m_ticks % OVS) == 0;
                    m_el = 0;
                    m_n = l ? req : m_shadow;
                    m_shadow = m_n; m_pend = 0;
                end
                m_clk = (m_el >= m_n / 2);
            end
            if (!wrapped && l) begin
                m_shadow = req;
                m_pend = 1;
            end
        end
    endtask

    // Called at a negedge; applies inputs for one rising edge and checks all
    // outputs against the reference afterwards.
    task automatic cycle(input bit e, input bit r, input bit l, input int unsigned v);
        en = e; restart = r; div_load = l; div_value = v[15:0];
        @(posedge clk200);
        model_edge(e, r, l, v);
        edge_no++;
        #1;
        chk("tick_ovs", 32'(tick_ovs), 32'(m_tovs));
        chk("tick_bit", 32'(tick_bit), 32'(m_tbit));
        chk("clkout", 32'(clkout), 32'(m_clk));
        chk("div_active", 32'(div_active), m_n);
        chk("div_pending", 32'(div_pending), 32'(m_pend));
        if (tick_ovs && first_tovs == 0) first_tovs = edge_no;
        if (tick_bit && first_tbit == 0) first_tbit = edge_no;
        @(negedge clk200);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; div_load = 1'b0; div_value = '0;
        model_reset();
        repeat (3) @(negedge clk200);
        chk("rst_tick_ovs", 32'(tick_ovs), 0);
        chk("rst_tick_bit", 32'(tick_bit), 0);
        chk("rst_clkout", 32'(clkout), 0);
        chk("rst_div_active", 32'(div_active), 1302);
        chk("rst_div_pending", 32'(div_pending), 0);
        rst_n = 1'b1;

        // Default divisor from reset release
        run(20932);
        chk("first_tick_ovs_edge", 32'(first_tovs), 1302);
        chk("first_tick_bit_edge", 32'(first_tbit), 20832);

        // Load N=5 at cnt=100; applies at the following wrap
        cycle(1'b1, 1'b0, 1'b1, 5);
        chk("pending_after_load", 32'(div_pending), 1);
        run(1250);

        // Divisors 0 then 1 clamp to 2
        cycle(1'b1, 1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 1'b1, 1);
        run(20);
        chk("clamped_div", 32'(div_active), 2);

        // en low for 37 cycles mid-period
        cycle(1'b1, 1'b0, 1'b1, 40);
        run(60);
        for (int i = 0; i < 37; i++) cycle(1'b0, 1'b0, 1'b0, 0);
        run(100);

        // restart with simultaneous load while en is low
        run(23);
        cycle(1'b0, 1'b1, 1'b1, 10);
        chk("restart_div_active", 32'(div_active), 10);
        chk("restart_pending", 32'(div_pending), 0);
        run(30);

        // Random mix of enables, restarts and loads
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 8) != 0, ($urandom % 97) == 0,
                  ($urandom % 53) == 0, $urandom % 41);
        end

        // Asynchronous reset mid-period with a load pending
        cycle(1'b1, 1'b1, 1'b1, 1302);
        run(700);
        cycle(1'b1, 1'b0, 1'b1, 7);
        chk("pre_reset_clkout", 32'(clkout), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_tick_ovs", 32'(tick_ovs), 0);
        chk("async_clkout", 32'(clkout), 0);
        chk("async_div_active", 32'(div_active), 1302);
        chk("async_div_pending", 32'(div_pending), 0);
        @(negedge clk200);
        rst_n = 1'b1;
        model_reset();
        run(1310);
        chk("post_reset_first_tick", 32'(first_tovs), 1302);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
